lifo_stack: RTL
===============

// Module: lifo_stack
// PURPOSE
//   Parametrised LIFO stack, next generation of the 32x16 stack block. Adds true full/empty
//   tracking, flow-controlled push/pop, same-cycle push+pop (replace top), occupancy count,
//   sync clear and sticky overflow/underflow flags. Used as operand/return stack by the datapath.
// PARAMETERS
//   DW     32  data width in bits (>=1)
//   DEPTH  16  number of entries (>=2, any integer, not only powers of 2)
//   AW     $clog2(DEPTH), localparam, stack-pointer index width
// PORTS
//   CLK       in   1      clock, all logic on rising edge
//   RST_N     in   1      asynchronous, active-low reset
//   CLR       in   1      synchronous clear: empties stack, clears flags
//   PUSH_STB  in   1      push request
//   PUSH_DAT  in   DW     push data
//   PUSH_ACK  out  1      push accepted this cycle (combinational)
//   POP_STB   in   1      pop request
//   POP_DAT   out  DW     popped data, registered, valid while POP_ACK=1, held otherwise
//   POP_ACK   out  1      one-cycle pulse, cycle after an accepted pop
//   COUNT     out  AW+1   current occupancy, 0..DEPTH
//   EMPTY     out  1      COUNT==0
//   FULL      out  1      COUNT==DEPTH
//   OVF       out  1      sticky: a push was refused
//   UDF       out  1      sticky: a pop was refused
// BEHAVIOUR
//   - Reset (RST_N=0): COUNT=0, EMPTY=1, FULL=0, POP_DAT=0, POP_ACK=0, OVF=0, UDF=0.
//     Storage array is not reset; contents above COUNT are don't-care.
//   - pop_ok  = POP_STB & ~EMPTY & ~CLR
//   - push_ok = PUSH_STB & ~CLR & (~FULL | pop_ok);  PUSH_ACK = push_ok
//   - Push only: mem[COUNT] <= PUSH_DAT; COUNT+1.
//   - Pop only: POP_DAT <= mem[COUNT-1]; COUNT-1; POP_ACK=1 next cycle.
//   - Push+pop both ok (incl. FULL): POP_DAT <= old top mem[COUNT-1]; mem[COUNT-1] <= PUSH_DAT;
//     COUNT unchanged; POP_ACK=1 next cycle.
//   - Push+pop while EMPTY: pop refused (UDF set), push accepted; no pass-through.
//   - Push while FULL without pop: PUSH_ACK=0, no write, OVF<=1. Pop while EMPTY: UDF<=1, POP_ACK=0.
//   - CLR: priority over push/pop; no accept, COUNT<=0, OVF/UDF<=0, POP_ACK<=0; POP_DAT held.
//   - Latency: push visible to a pop issued the next cycle; pop data 1 cycle after acceptance.
//   - COUNT never wraps; EMPTY/FULL derived from registered COUNT, no combinational path from STB.
//   - Reset asserted mid-operation: immediate return to reset state; in-flight POP_ACK dropped.
// STRUCTURE
//   - Package lifo_pkg: default DW/DEPTH constants, function for count-width calc.
//   - Sub-module lifo_ram: DEPTH x DW register array, one sync write port, one async read port
//     at address COUNT-1 (top). Control/pointer/flag logic stays in lifo_stack.
// TESTING (DW=32, DEPTH=16 unless noted)
//   1 Reset: RST_N low mid-traffic -> COUNT=0, EMPTY=1, POP_ACK=0, OVF=UDF=0 without CLK edge.
//   2 Push 0x11..0x20 (16 values), then 17th push 0xFF -> FULL=1, 17th PUSH_ACK=0, OVF=1;
//     16 pops return 0x20 down to 0x11, each with POP_ACK one cycle later, then EMPTY=1.
//   3 Empty stack, POP_STB=1 -> POP_ACK stays 0, UDF=1, POP_DAT unchanged; CLR -> UDF=0.
//   4 Stack holds A,B (B top); push C + pop same cycle -> POP_DAT=B, COUNT=2, next pop returns C.
//   5 FULL, push 0x55 + pop same cycle -> PUSH_ACK=1, OVF stays 0, COUNT=16, top becomes 0x55.
//   6 DEPTH=5 build: 5 pushes -> FULL, COUNT=5; CLR together with PUSH_STB -> PUSH_ACK=0, COUNT=0.

Source files
------------

// File: rtl/lifo_pkg.sv
// Shared defaults and width helpers for the LIFO stack and its storage array.
package lifo_pkg;

  localparam int unsigned LIFO_DW_DEF    = 32;
  localparam int unsigned LIFO_DEPTH_DEF = 16;

  // Occupancy needs one extra bit beyond the index width so that DEPTH itself is representable.
  function automatic int unsigned lifo_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lifo_ram.sv
// DEPTH x DW register array: one synchronous write port, one asynchronous read port.
module lifo_ram
  import lifo_pkg::*;
#(
  parameter int unsigned DW    = LIFO_DW_DEF,
  parameter int unsigned DEPTH = LIFO_DEPTH_DEF,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // With a non-power-of-two depth the top index wraps past DEPTH-1 when the stack is empty.
  always_comb begin
    rdata = '0;
    if (32'(raddr) < DEPTH) begin
      rdata = mem_q[raddr];
    end
  end

endmodule

// File: rtl/lifo_stack.sv
// Parametrised LIFO with flow-controlled push/pop, same-cycle replace, occupancy and sticky flags.
module lifo_stack
  import lifo_pkg::*;
#(
  parameter int unsigned DW    = LIFO_DW_DEF,
  parameter int unsigned DEPTH = LIFO_DEPTH_DEF,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = lifo_cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push_stb,
  input  logic [DW-1:0] push_dat,
  output logic          push_ack,
  input  logic          pop_stb,
  output logic [DW-1:0] pop_dat,
  output logic          pop_ack,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic          udf
);

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] pop_dat_q, pop_dat_d;
  logic          pop_ack_q, pop_ack_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic          pop_ok, push_ok;
  logic          we;
  logic [AW-1:0] top_idx, waddr;
  logic [DW-1:0] top_dat;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign pop_ok  = pop_stb & ~empty & ~clr;
  assign push_ok = push_stb & ~clr & (~full | pop_ok);
  assign top_idx = count_q[AW-1:0] - 1'b1;

  // A push paired with an accepted pop overwrites the current top instead of growing the stack.
  assign we    = push_ok;
  assign waddr = pop_ok ? top_idx : count_q[AW-1:0];

  lifo_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (push_dat),
    .raddr (top_idx),
    .rdata (top_dat)
  );

  always_comb begin
    count_d   = count_q;
    pop_dat_d = pop_dat_q;
    pop_ack_d = pop_ok;
    ovf_d     = ovf_q | (push_stb & ~push_ok);
    udf_d     = udf_q | (pop_stb & ~pop_ok);
    if (pop_ok) begin
      pop_dat_d = top_dat;
    end
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      pop_dat_q <= '0;
      pop_ack_q <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      pop_dat_q <= pop_dat_d;
      pop_ack_q <= pop_ack_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  assign push_ack = push_ok;
  assign pop_dat  = pop_dat_q;
  assign pop_ack  = pop_ack_q;
  assign count    = count_q;
  assign ovf      = ovf_q;
  assign udf      = udf_q;

endmodule
